// File: rtl/gravador_sequencia_pkg.sv
// Shared definitions for the sequence recorder: state codes, store geometry
// and default timing.
package gravador_sequencia_pkg;

    localparam int RAM_PROF         = 16;
    localparam int RAM_END_W        = 4;
    localparam int RAM_DADO_W       = 4;
    localparam int TIMEOUT_PADRAO   = 5000;
    localparam int TIMEOUT_W_PADRAO = 13;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        ESPERA  = 3'd1,
        GRAVA   = 3'd2,
        FINAL   = 3'd3
    } estado_t;

    // True when exactly one key is pressed.
    function automatic logic um_quente(input logic [RAM_DADO_W-1:0] valor);
        return (valor != '0) && ((valor & (valor - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/gravador_sequencia_ram.sv
// 16x4 sequence store: one write port, registered read port with
// read-before-write behaviour; interface mirrors the 16x4 sequence ROM.
module ram_sync_16x4
    import gravador_sequencia_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [RAM_END_W-1:0]  wr_endereco,
    input  logic [RAM_DADO_W-1:0] wr_dado,
    input  logic [RAM_END_W-1:0]  rd_endereco,
    output logic [RAM_DADO_W-1:0] rd_dado
);

    logic [RAM_DADO_W-1:0] mem [RAM_PROF];

    // NOTE: the array has no reset so it maps onto RAM primitives; only the
    // read register is cleared.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_endereco] <= wr_dado;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_dado <= '0;
        end else begin
            rd_dado <= mem[rd_endereco];
        end
    end

endmodule

// File: rtl/gravador_sequencia.sv
// Sequence recorder: captures one-hot key presses into the sequence store
// until confirmation, a full store or an idle timeout.
module gravador_sequencia
    import gravador_sequencia_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_PADRAO,
    parameter int TIMEOUT_W = TIMEOUT_W_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic                  confirma,
    input  logic [RAM_DADO_W-1:0] chaves,
    input  logic [RAM_END_W-1:0]  rd_endereco,
    output logic [RAM_DADO_W-1:0] rd_dado,
    output logic [RAM_END_W:0]    tamanho,
    output logic [RAM_END_W-1:0]  ultimo,
    output logic                  gravando,
    output logic                  pronto,
    output logic                  timeout,
    output logic                  erro_chave,
    output logic [RAM_DADO_W-1:0] leds,
    output logic [2:0]            db_estado
);

    localparam logic [TIMEOUT_W-1:0] LIMITE    = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [RAM_END_W:0]   TAM_CHEIO = (RAM_END_W + 1)'(RAM_PROF - 1);

    estado_t               estado;
    logic [TIMEOUT_W-1:0]  contador;
    logic                  chaves_ant;
    logic [RAM_DADO_W-1:0] valor;
    logic                  borda;
    logic                  escreve;

    assign borda = (|chaves) & ~chaves_ant;

    // A write still pending in GRAVA is dropped when reset hits that edge.
    assign escreve = (estado == GRAVA) && !reset;

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the values from before this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            tamanho    <= '0;
            contador   <= '0;
            chaves_ant <= 1'b0;
            valor      <= '0;
            timeout    <= 1'b0;
            erro_chave <= 1'b0;
            gravando   <= 1'b0;
            pronto     <= 1'b0;
        end else begin
            chaves_ant <= |chaves;
            erro_chave <= 1'b0;
            case (estado)
                INICIAL, FINAL: begin
                    if (iniciar) begin
                        estado   <= ESPERA;
                        tamanho  <= '0;
                        contador <= '0;
                        timeout  <= 1'b0;
                        gravando <= 1'b1;
                        pronto   <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (confirma && tamanho != '0) begin
                        estado   <= FINAL;
                        gravando <= 1'b0;
                        pronto   <= 1'b1;
                    end else if (borda && um_quente(chaves)) begin
                        valor    <= chaves;
                        contador <= '0;
                        estado   <= GRAVA;
                    end else begin
                        erro_chave <= borda;
                        if (contador == LIMITE) begin
                            estado   <= FINAL;
                            timeout  <= 1'b1;
                            gravando <= 1'b0;
                            pronto   <= (tamanho != '0);
                        end else begin
                            contador <= contador + 1'b1;
                        end
                    end
                end
                GRAVA: begin
                    tamanho <= tamanho + 1'b1;
                    if (tamanho == TAM_CHEIO) begin
                        estado   <= FINAL;
                        gravando <= 1'b0;
                        pronto   <= 1'b1;
                    end else begin
                        estado <= ESPERA;
                    end
                end
                default: begin
                    estado   <= INICIAL;
                    gravando <= 1'b0;
                    pronto   <= 1'b0;
                end
            endcase
        end
    end

    assign ultimo    = (tamanho == '0) ? '0 : RAM_END_W'(tamanho - 1'b1);
    assign leds      = gravando ? chaves : '0;
    assign db_estado = estado;

    ram_sync_16x4 u_ram (
        .clock       (clock),
        .reset       (reset),
        .we          (escreve),
        .wr_endereco (tamanho[RAM_END_W-1:0]),
        .wr_dado     (valor),
        .rd_endereco (rd_endereco),
        .rd_dado     (rd_dado)
    );

endmodule

// File: tb/tb_gravador_sequencia.sv
// Self-checking bench for gravador_sequencia: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_gravador_sequencia;

    localparam int T = 20;

    logic       clock = 1'b0;
    logic       reset, iniciar, confirma;
    logic [3:0] chaves, rd_endereco;
    logic [3:0] rd_dado, ultimo, leds;
    logic [4:0] tamanho;
    logic       gravando, pronto, timeout, erro_chave;
    logic [2:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    gravador_sequencia #(.TIMEOUT(T), .TIMEOUT_W(13)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .confirma    (confirma),
        .chaves      (chaves),
        .rd_endereco (rd_endereco),
        .rd_dado     (rd_dado),
        .tamanho     (tamanho),
        .ultimo      (ultimo),
        .gravando    (gravando),
        .pronto      (pronto),
        .timeout     (timeout),
        .erro_chave  (erro_chave),
        .leds        (leds),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input int atual, input int esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 waiting for key, 2 storing, 3 done.
    int         m_mode, m_len, m_idle;
    bit         m_to, m_err, m_prev;
    logic [3:0] m_held;
    logic [3:0] m_mem [16];
    bit         m_ok  [16];
    logic [3:0] m_rd;
    bit         m_rd_ok;

    task automatic model_step();
        bit press, valido;
        int a;
        if (reset) begin
            m_mode = 0; m_len = 0; m_idle = 0; m_to = 0; m_err = 0; m_prev = 0;
            m_rd = 4'd0; m_rd_ok = 1;
            return;
        end
        a       = int'(rd_endereco);
        m_rd    = m_mem[a];
        m_rd_ok = m_ok[a];
        press   = (chaves != 4'd0) && !m_prev;
        valido  = ($countones(chaves) == 1);
        m_err   = 0;
        case (m_mode)
            0, 3: if (iniciar) begin m_mode = 1; m_len = 0; m_idle = 0; m_to = 0; end
            1: begin
                if (confirma && m_len > 0) m_mode = 3;
                else if (press && valido) begin m_held = chaves; m_idle = 0; m_mode = 2; end
                else begin
                    m_err = press;
                    if (m_idle == T - 1) begin m_mode = 3; m_to = 1; end
                    else m_idle++;
                end
            end
            2: begin
                m_mem[m_len] = m_held;
                m_ok[m_len]  = 1;
                m_len++;
                m_mode = (m_len == 16) ? 3 : 1;
            end
            default: m_mode = 0;
        endcase
        m_prev = (chaves != 4'd0);
    endtask

    task automatic compare_model();
        bit g;
        g = (m_mode == 1 || m_mode == 2);
        check("estado", int'(db_estado), m_mode);
        check("tamanho", int'(tamanho), m_len);
        check("ultimo", int'(ultimo), (m_len > 0) ? m_len - 1 : 0);
        check("gravando", int'(gravando), int'(g));
        check("pronto", int'(pronto), int'(m_mode == 3 && m_len > 0));
        check("timeout", int'(timeout), int'(m_to));
        check("erro_chave", int'(erro_chave), int'(m_err));
        check("leds", int'(leds), g ? int'(chaves) : 0);
        if (m_rd_ok) check("rd_dado", int'(rd_dado), int'(m_rd));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic r, input logic i, input logic c, input logic [3:0] k);
        reset = r; iniciar = i; confirma = c; chaves = k;
    endtask

    typedef struct {
        logic       rst, ini, conf;
        logic [3:0] ch, addr;
        int         estado, tam;
        logic       grav, pr, err, rd_chk;
        logic [3:0] rd;
    } vetor_t;

    vetor_t tabela [20];

    initial begin
        drive(1, 0, 0, 4'd0);
        rd_endereco = 4'd0;

        //            rst ini conf ch       addr  est tam g  p  e  rdc rd
        tabela[0]  = '{1, 0, 0, 4'b0000, 4'd0, 0, 0, 0, 0, 0, 0, 4'd0};
        tabela[1]  = '{0, 1, 0, 4'b0000, 4'd0, 1, 0, 1, 0, 0, 0, 4'd0};
        tabela[2]  = '{0, 0, 0, 4'b0001, 4'd0, 2, 0, 1, 0, 0, 0, 4'd0};
        tabela[3]  = '{0, 0, 0, 4'b0001, 4'd0, 1, 1, 1, 0, 0, 0, 4'd0};
        tabela[4]  = '{0, 0, 0, 4'b0000, 4'd0, 1, 1, 1, 0, 0, 0, 4'd0};
        tabela[5]  = '{0, 0, 0, 4'b0100, 4'd0, 2, 1, 1, 0, 0, 0, 4'd0};
        tabela[6]  = '{0, 0, 0, 4'b0000, 4'd0, 1, 2, 1, 0, 0, 0, 4'd0};
        tabela[7]  = '{0, 0, 0, 4'b1000, 4'd0, 2, 2, 1, 0, 0, 0, 4'd0};
        tabela[8]  = '{0, 0, 0, 4'b0000, 4'd0, 1, 3, 1, 0, 0, 0, 4'd0};
        tabela[9]  = '{0, 0, 1, 4'b0000, 4'd0, 3, 3, 0, 1, 0, 1, 4'b0001};
        tabela[10] = '{0, 0, 0, 4'b0000, 4'd0, 3, 3, 0, 1, 0, 1, 4'b0001};
        tabela[11] = '{0, 0, 0, 4'b0000, 4'd1, 3, 3, 0, 1, 0, 1, 4'b0100};
        tabela[12] = '{0, 0, 0, 4'b0000, 4'd2, 3, 3, 0, 1, 0, 1, 4'b1000};
        tabela[13] = '{0, 1, 0, 4'b0000, 4'd0, 1, 0, 1, 0, 0, 0, 4'd0};
        tabela[14] = '{0, 0, 0, 4'b0011, 4'd0, 1, 0, 1, 0, 1, 0, 4'd0};
        tabela[15] = '{0, 0, 0, 4'b0011, 4'd0, 1, 0, 1, 0, 0, 0, 4'd0};
        tabela[16] = '{0, 0, 0, 4'b0000, 4'd0, 1, 0, 1, 0, 0, 0, 4'd0};
        tabela[17] = '{0, 0, 0, 4'b0010, 4'd0, 2, 0, 1, 0, 0, 0, 4'd0};
        tabela[18] = '{0, 0, 0, 4'b0000, 4'd0, 1, 1, 1, 0, 0, 0, 4'd0};
        tabela[19] = '{0, 0, 1, 4'b0000, 4'd0, 3, 1, 0, 1, 0, 1, 4'b0010};

        for (int i = 0; i < 20; i++) begin
            drive(tabela[i].rst, tabela[i].ini, tabela[i].conf, tabela[i].ch);
            rd_endereco = tabela[i].addr;
            tick();
            check("tab_estado", int'(db_estado), tabela[i].estado);
            check("tab_tamanho", int'(tamanho), tabela[i].tam);
            check("tab_ultimo", int'(ultimo), (tabela[i].tam > 0) ? tabela[i].tam - 1 : 0);
            check("tab_gravando", int'(gravando), int'(tabela[i].grav));
            check("tab_pronto", int'(pronto), int'(tabela[i].pr));
            check("tab_erro", int'(erro_chave), int'(tabela[i].err));
            if (tabela[i].rd_chk) check("tab_rd_dado", int'(rd_dado), int'(tabela[i].rd));
        end

        // Timeout with nothing recorded.
        drive(0, 1, 0, 4'd0); tick();
        drive(0, 0, 0, 4'd0);
        for (int i = 1; i < T; i++) tick();
        check("to_vazio_espera", int'(db_estado), 1);
        tick();
        check("to_vazio_estado", int'(db_estado), 3);
        check("to_vazio_flag", int'(timeout), 1);
        check("to_vazio_pronto", int'(pronto), 0);

        // Timeout after two presses.
        drive(0, 1, 0, 4'd0); tick();
        drive(0, 0, 0, 4'b0001); tick();
        drive(0, 0, 0, 4'b0000); tick();
        drive(0, 0, 0, 4'b0010); tick();
        drive(0, 0, 0, 4'b0000); tick();
        for (int i = 1; i < T; i++) tick();
        check("to_dois_espera", int'(db_estado), 1);
        tick();
        check("to_dois_estado", int'(db_estado), 3);
        check("to_dois_flag", int'(timeout), 1);
        check("to_dois_pronto", int'(pronto), 1);
        check("to_dois_tamanho", int'(tamanho), 2);

        // Sixteen presses fill the store, a seventeenth is ignored.
        drive(0, 1, 0, 4'd0); tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 4'b0001 << (i % 4)); tick();
            drive(0, 0, 0, 4'b0000); tick();
        end
        check("cheio_estado", int'(db_estado), 3);
        check("cheio_tamanho", int'(tamanho), 16);
        check("cheio_ultimo", int'(ultimo), 15);
        check("cheio_pronto", int'(pronto), 1);
        drive(0, 0, 0, 4'b0100); tick();
        drive(0, 0, 0, 4'b0000); tick();
        check("cheio_17_tamanho", int'(tamanho), 16);
        check("cheio_17_estado", int'(db_estado), 3);
        rd_endereco = 4'd15; tick();
        check("cheio_rd15", int'(rd_dado), 4'b1000);

        // Restart from FINAL, then confirma and a valid press in the same cycle.
        rd_endereco = 4'd0;
        drive(0, 1, 0, 4'd0); tick();
        check("reinicio_tamanho", int'(tamanho), 0);
        drive(0, 0, 0, 4'b0010); tick();
        drive(0, 0, 0, 4'b0000); tick();
        drive(0, 0, 1, 4'b0001); tick();
        check("simult_estado", int'(db_estado), 3);
        check("simult_tamanho", int'(tamanho), 1);
        drive(0, 0, 0, 4'b0001); tick(); tick();
        check("simult_segura", int'(tamanho), 1);

        // Reset during GRAVA drops the write.
        drive(0, 1, 0, 4'd0); tick();
        drive(0, 0, 0, 4'b0100); tick();
        drive(0, 0, 0, 4'b0000); tick();
        drive(0, 0, 1, 4'b0000); tick();
        drive(0, 1, 0, 4'b0000); tick();
        drive(0, 0, 0, 4'b0001); tick();
        check("rst_grava_pre", int'(db_estado), 2);
        drive(1, 0, 0, 4'b0001); tick();
        check("rst_grava_estado", int'(db_estado), 0);
        check("rst_grava_tamanho", int'(tamanho), 0);
        check("rst_grava_gravando", int'(gravando), 0);
        drive(0, 0, 0, 4'b0000); rd_endereco = 4'd0; tick();
        check("rst_grava_mem", int'(rd_dado), 4'b0100);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            reset    = ($urandom_range(0, 299) == 0);
            iniciar  = ($urandom_range(0, 15) == 0);
            confirma = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 7);
                if (r < 4)      chaves = 4'd0;
                else if (r < 7) chaves = 4'b0001 << $urandom_range(0, 3);
                else            chaves = 4'($urandom_range(0, 15));
            end
            rd_endereco = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
